// File: rtl/wm_cycle_controller.sv
// rtl/wm_cycle_controller.sv - washing-machine cycle sequencer (fill, heat, wash, rinse, spin)
// Moore FSM with pause/resume, cancel and a per-phase watchdog; actuators are registered from next state.
module wm_cycle_controller #(
  parameter int STATE_TIMEOUT = 16,
  parameter int WD_WIDTH      = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       door_closed,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       cancel_btn,
  input  logic       heat_en,
  input  logic       sig_Full,
  input  logic       sig_Temperature,
  input  logic       sig_Wash_Completed,
  input  logic       sig_Rinse_Completed,
  input  logic       sig_Spin_Completed,
  output logic [2:0] state,
  output logic       water_valve,
  output logic       heater,
  output logic       motor,
  output logic       drain,
  output logic       door_lock,
  output logic       done,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_READY = 3'd1,
    S_FILL  = 3'd2,
    S_HEAT  = 3'd3,
    S_WASH  = 3'd4,
    S_RINSE = 3'd5,
    S_SPIN  = 3'd6,
    S_PAUSE = 3'd7
  } state_t;

  localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(STATE_TIMEOUT - 1);

  state_t              cur_state;
  state_t              nxt_state;
  state_t              saved_state;
  state_t              nxt_saved;
  logic                heat_latch;
  logic                nxt_heat_latch;
  logic [WD_WIDTH-1:0] watchdog;
  logic [WD_WIDTH-1:0] nxt_watchdog;
  logic                nxt_fault;
  logic                nxt_done;
  logic                active;
  logic                pausable;
  logic                nxt_valve;
  logic                nxt_heater;
  logic                nxt_motor;
  logic                nxt_drain;
  logic                nxt_lock;

  assign state = cur_state;

  always_comb begin
    nxt_state      = cur_state;
    nxt_saved      = saved_state;
    nxt_heat_latch = heat_latch;
    nxt_fault      = fault;
    nxt_done       = 1'b0;
    active   = (cur_state inside {S_FILL, S_HEAT, S_WASH, S_RINSE, S_SPIN});
    pausable = (cur_state inside {S_FILL, S_HEAT, S_WASH, S_RINSE});

    if (cancel_btn) begin
      nxt_fault = 1'b0;
    end

    if (cancel_btn && (cur_state != S_START)) begin
      nxt_state = S_START;
    end else if (active && (watchdog == WD_LIMIT)) begin
      nxt_state = S_START;
      nxt_fault = 1'b1;
    end else if (pausable && (pause_btn || !door_closed)) begin
      nxt_state = S_PAUSE;
      nxt_saved = cur_state;
    end else begin
      // Each phase looks only at its own flag; earlier flags stay high until START/READY.
      case (cur_state)
        S_START: begin
          if (door_closed) nxt_state = S_READY;
        end
        S_READY: begin
          if (!door_closed) begin
            nxt_state = S_START;
          end else if (start_btn && !fault) begin
            nxt_state      = S_FILL;
            nxt_heat_latch = heat_en;
          end
        end
        S_FILL: begin
          if (sig_Full) nxt_state = heat_latch ? S_HEAT : S_WASH;
        end
        S_HEAT: begin
          if (sig_Temperature) nxt_state = S_WASH;
        end
        S_WASH: begin
          if (sig_Wash_Completed) nxt_state = S_RINSE;
        end
        S_RINSE: begin
          if (sig_Rinse_Completed) nxt_state = S_SPIN;
        end
        S_SPIN: begin
          if (sig_Spin_Completed) begin
            nxt_state = S_START;
            nxt_done  = 1'b1;
          end
        end
        S_PAUSE: begin
          if (start_btn && door_closed && !pause_btn) nxt_state = saved_state;
        end
        default: nxt_state = S_START;
      endcase
    end
  end

  // Pause time is not counted: the count restarts on every state change, including resume.
  always_comb begin
    nxt_watchdog = watchdog;
    if (!active || (nxt_state != cur_state)) begin
      nxt_watchdog = '0;
    end else if (watchdog != WD_LIMIT) begin
      nxt_watchdog = watchdog + WD_WIDTH'(1);
    end
  end

  always_comb begin
    nxt_valve  = 1'b0;
    nxt_heater = 1'b0;
    nxt_motor  = 1'b0;
    nxt_drain  = 1'b0;
    nxt_lock   = 1'b0;
    case (nxt_state)
      S_FILL: begin
        nxt_valve = 1'b1;
        nxt_lock  = 1'b1;
      end
      S_HEAT: begin
        nxt_heater = 1'b1;
        nxt_lock   = 1'b1;
      end
      S_WASH: begin
        nxt_motor = 1'b1;
        nxt_lock  = 1'b1;
      end
      S_RINSE: begin
        nxt_valve = 1'b1;
        nxt_motor = 1'b1;
        nxt_lock  = 1'b1;
      end
      S_SPIN: begin
        nxt_motor = 1'b1;
        nxt_drain = 1'b1;
        nxt_lock  = 1'b1;
      end
      default: begin
        nxt_lock = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state   <= S_START;
      saved_state <= S_START;
      heat_latch  <= 1'b0;
      watchdog    <= '0;
      fault       <= 1'b0;
      done        <= 1'b0;
      water_valve <= 1'b0;
      heater      <= 1'b0;
      motor       <= 1'b0;
      drain       <= 1'b0;
      door_lock   <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      saved_state <= nxt_saved;
      heat_latch  <= nxt_heat_latch;
      watchdog    <= nxt_watchdog;
      fault       <= nxt_fault;
      done        <= nxt_done;
      water_valve <= nxt_valve;
      heater      <= nxt_heater;
      motor       <= nxt_motor;
      drain       <= nxt_drain;
      door_lock   <= nxt_lock;
    end
  end

endmodule

// File: tb/tb_wm_cycle_controller.sv
// tb/tb_wm_cycle_controller.sv - self-checking bench for wm_cycle_controller
// Vector table plus timed sequences for watchdog and a timer-driven hot cycle with pause.
module tb_wm_cycle_controller;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       door = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       cancel = 1'b0;
  logic       heat = 1'b0;
  logic [4:0] vflags = 5'b0;
  logic [4:0] tflag;
  logic       tm_en = 1'b0;
  logic [4:0] flags;
  logic [2:0] dut_state;
  logic       water_valve, heater, motor, drain, door_lock, done, fault;

  int tests = 0;
  int failed = 0;

  assign flags = tm_en ? tflag : vflags;

  wm_cycle_controller #(.STATE_TIMEOUT(8), .WD_WIDTH(5)) dut (
    .clock(clock),
    .reset(rst),
    .door_closed(door),
    .start_btn(start),
    .pause_btn(pause),
    .cancel_btn(cancel),
    .heat_en(heat),
    .sig_Full(flags[0]),
    .sig_Temperature(flags[1]),
    .sig_Wash_Completed(flags[2]),
    .sig_Rinse_Completed(flags[3]),
    .sig_Spin_Completed(flags[4]),
    .state(dut_state),
    .water_valve(water_valve),
    .heater(heater),
    .motor(motor),
    .drain(drain),
    .door_lock(door_lock),
    .done(done),
    .fault(fault)
  );

  always #5 clock = ~clock;

  // Phase timer model: fill 2 / heat 3 / wash 5 / rinse 3 / spin 3, held in PAUSE.
  int tlen[5] = '{2, 3, 5, 3, 3};
  int tcnt[5];
  always @(posedge clock) begin
    if (rst || dut_state <= 3'd1) begin
      for (int k = 0; k < 5; k++) tcnt[k] <= 0;
      tflag <= 5'b0;
    end else if (dut_state >= 3'd2 && dut_state <= 3'd6) begin
      if (!tflag[dut_state - 3'd2]) begin
        tcnt[dut_state - 3'd2] <= tcnt[dut_state - 3'd2] + 1;
        if (tcnt[dut_state - 3'd2] + 1 >= tlen[dut_state - 3'd2]) tflag[dut_state - 3'd2] <= 1'b1;
      end
    end
  end

  typedef struct {
    string      name;
    logic       r, d, s, p, c, h;
    logic [4:0] f;
    logic [2:0] st;
    logic [4:0] act;
    logic       dn, flt;
  } vec_t;

  vec_t vecs[$];

  localparam logic [4:0] A0 = 5'b00000;
  localparam logic [4:0] AF = 5'b10001;
  localparam logic [4:0] AH = 5'b01001;
  localparam logic [4:0] AW = 5'b00101;
  localparam logic [4:0] AR = 5'b10101;
  localparam logic [4:0] AS = 5'b00111;

  task automatic add(input string nm, input logic r, d, s, p, c, h, input logic [4:0] f,
                     input logic [2:0] st, input logic [4:0] a, input logic dn, flt);
    vec_t v;
    v.name = nm; v.r = r; v.d = d; v.s = s; v.p = p; v.c = c; v.h = h;
    v.f = f; v.st = st; v.act = a; v.dn = dn; v.flt = flt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [4:0] acts();
    return {water_valve, heater, motor, drain, door_lock};
  endfunction

  int visited[$];
  int last_st;
  int wash_n;
  int done_n;
  int lock_err;

  task automatic tstep();
    step();
    if (int'(dut_state) != last_st) begin
      visited.push_back(int'(dut_state));
      last_st = int'(dut_state);
    end
    if (dut_state == 3'd4) wash_n++;
    if (done) done_n++;
    if (door_lock !== (dut_state >= 3'd2 && dut_state <= 3'd6)) lock_err++;
  endtask

  initial begin
    int n;
    bit paused;
    int exp_vis[10] = '{0, 1, 2, 3, 4, 7, 4, 5, 6, 0};

    //   name        r d s p c h  flags     st    act dn flt
    add("reset",     1,0,0,0,0,0, 5'b00000, 3'd0, A0, 0, 0);
    add("hot_ready", 0,1,0,0,0,0, 5'b00000, 3'd1, A0, 0, 0);
    add("hot_fill",  0,1,1,0,0,1, 5'b00000, 3'd2, AF, 0, 0);
    add("hot_hold",  0,1,0,0,0,0, 5'b00000, 3'd2, AF, 0, 0);
    add("hot_heat",  0,1,0,0,0,0, 5'b00001, 3'd3, AH, 0, 0);
    add("hot_wash",  0,1,0,0,0,0, 5'b00011, 3'd4, AW, 0, 0);
    add("hot_rinse", 0,1,0,0,0,0, 5'b00111, 3'd5, AR, 0, 0);
    add("hot_spin",  0,1,0,0,0,0, 5'b01111, 3'd6, AS, 0, 0);
    add("spin_door", 0,0,0,1,0,0, 5'b01111, 3'd6, AS, 0, 0);
    add("spin_done", 0,0,0,1,0,0, 5'b11111, 3'd0, A0, 1, 0);
    add("done_off",  0,0,0,0,0,0, 5'b11111, 3'd0, A0, 0, 0);
    add("cold_rdy",  0,1,0,0,0,0, 5'b00000, 3'd1, A0, 0, 0);
    add("cold_fill", 0,1,1,0,0,0, 5'b00000, 3'd2, AF, 0, 0);
    add("cold_wash", 0,1,0,0,0,1, 5'b00001, 3'd4, AW, 0, 0);
    add("cold_rins", 0,1,0,0,0,1, 5'b00101, 3'd5, AR, 0, 0);
    add("cxl_rinse", 0,1,0,0,1,0, 5'b01101, 3'd0, A0, 0, 0);
    add("c2_ready",  0,1,0,0,0,0, 5'b00000, 3'd1, A0, 0, 0);
    add("c2_fill",   0,1,1,0,0,0, 5'b00000, 3'd2, AF, 0, 0);
    add("c2_wash",   0,1,0,0,0,0, 5'b00001, 3'd4, AW, 0, 0);
    add("c2_rinse",  0,1,0,0,0,0, 5'b00101, 3'd5, AR, 0, 0);
    add("c2_spin",   0,1,0,0,0,0, 5'b01101, 3'd6, AS, 0, 0);
    add("cxl_spin",  0,1,0,0,1,0, 5'b11101, 3'd0, A0, 0, 0);
    add("p_ready",   0,1,0,0,0,0, 5'b00000, 3'd1, A0, 0, 0);
    add("p_fill",    0,1,1,0,0,0, 5'b00000, 3'd2, AF, 0, 0);
    add("door_full", 0,0,0,0,0,0, 5'b00001, 3'd7, A0, 0, 0);
    add("p_nostart", 0,1,0,0,0,0, 5'b00001, 3'd7, A0, 0, 0);
    add("p_resume",  0,1,1,0,0,0, 5'b00001, 3'd2, AF, 0, 0);
    add("p_advance", 0,1,0,0,0,0, 5'b00001, 3'd4, AW, 0, 0);
    add("pbtn_wash", 0,1,0,1,0,0, 5'b00001, 3'd7, A0, 0, 0);
    add("pbtn_held", 0,1,1,1,0,0, 5'b00001, 3'd7, A0, 0, 0);
    add("pbtn_res",  0,1,1,0,0,0, 5'b00001, 3'd4, AW, 0, 0);
    add("p_cancel",  0,1,0,0,1,0, 5'b00001, 3'd0, A0, 0, 0);
    add("r_ready",   0,1,0,0,0,0, 5'b00000, 3'd1, A0, 0, 0);
    add("r_fill",    0,1,1,0,0,0, 5'b00000, 3'd2, AF, 0, 0);
    add("r_wash",    0,1,0,0,0,0, 5'b00001, 3'd4, AW, 0, 0);
    add("r_rinse",   0,1,0,0,0,0, 5'b00101, 3'd5, AR, 0, 0);
    add("r_spin",    0,1,0,0,0,0, 5'b01101, 3'd6, AS, 0, 0);
    add("r_door",    0,0,0,0,0,0, 5'b01101, 3'd6, AS, 0, 0);
    add("r_reset",   1,0,0,0,0,0, 5'b01101, 3'd0, A0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].r; door = vecs[i].d; start = vecs[i].s;
      pause = vecs[i].p; cancel = vecs[i].c; heat = vecs[i].h;
      vflags = vecs[i].f;
      step();
      chk({vecs[i].name, "/state"}, 32'(dut_state), 32'(vecs[i].st));
      chk({vecs[i].name, "/outs"}, 32'({acts(), done, fault}),
          32'({vecs[i].act, vecs[i].dn, vecs[i].flt}));
    end
    rst = 1'b0; start = 1'b0; pause = 1'b0; cancel = 1'b0; vflags = 5'b0;

    // Watchdog: sig_Full never arrives, FILL lasts STATE_TIMEOUT cycles then faults.
    door = 1'b1;
    step();
    chk("wd_ready", 32'(dut_state), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("wd_fill", 32'(dut_state), 32'd2);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (dut_state != 3'd2) break;
    end
    chk("wd_cycles", 32'(n), 32'd8);
    chk("wd_state", 32'(dut_state), 32'd0);
    chk("wd_fault", 32'(fault), 32'd1);
    chk("wd_acts", 32'(acts()), 32'd0);
    step();
    chk("wd_to_ready", 32'({dut_state, fault}), 32'({3'd1, 1'b1}));
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    chk("wd_blocks_start", 32'({dut_state, fault}), 32'({3'd1, 1'b1}));
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("wd_cancel", 32'({dut_state, fault}), 32'({3'd0, 1'b0}));
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("wd_restart", 32'({dut_state, fault}), 32'({3'd2, 1'b0}));

    // Timer-driven hot cycle with a door-open pause in the middle of WASH.
    rst = 1'b1;
    step();
    rst = 1'b0;
    tm_en = 1'b1;
    door = 1'b1;
    heat = 1'b1;
    visited = {0};
    last_st = 0;
    wash_n = 0;
    done_n = 0;
    lock_err = 0;
    paused = 0;
    tstep();
    start = 1'b1;
    tstep();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (dut_state == 3'd4 && wash_n == 3 && !paused) begin
        paused = 1;
        door = 1'b0;
        tstep();
        tstep();
        tstep();
        chk("pause_state", 32'(dut_state), 32'd7);
        chk("pause_acts", 32'({motor, door_lock}), 32'd0);
        door = 1'b1;
        start = 1'b1;
        tstep();
        start = 1'b0;
        chk("resume_wash", 32'(dut_state), 32'd4);
      end else begin
        tstep();
      end
      if (dut_state == 3'd0) break;
    end
    chk("cycle_end", 32'(dut_state), 32'd0);
    chk("visit_count", 32'(visited.size()), 32'd10);
    for (int i = 0; i < 10 && i < visited.size(); i++)
      chk($sformatf("visit_%0d", i), 32'(visited[i]), 32'(exp_vis[i]));
    chk("wash_cycles", 32'(wash_n), 32'd6);
    chk("done_pulse", 32'(done), 32'd1);
    chk("lock_rule", 32'(lock_err), 32'd0);
    tstep();
    chk("done_once", 32'({done, 4'(done_n)}), 32'({1'b0, 4'd1}));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
